// File: rtl/alu_exec_ctrl_if.sv
// Execute-stage bus: decoded-op handshake, ALU drive/return,
// EX/MEM result buffer and condition-code status.
interface alu_exec_ctrl_if #(
    parameter int N    = 16,
    parameter int RA_W = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [N-1:0]    in_src;
    logic [N-1:0]    in_dst;
    logic [RA_W-1:0] in_rd;
    logic            out_ready;
    logic            flush;
    logic            flags_save;
    logic            flags_restore;
    logic [1:0]      alu_ctrl;
    logic [N-1:0]    alu_src;
    logic [N-1:0]    alu_dst;
    logic [N-1:0]    alu_out;
    logic            alu_c;
    logic            alu_z;
    logic            alu_n;
    logic            out_valid;
    logic [N-1:0]    out_result;
    logic [RA_W-1:0] out_rd;
    logic            out_wb;
    logic [2:0]      ccr;
    logic            illegal_op;
    logic [15:0]     retired;

    modport slave (
        input  in_valid, in_op, in_src, in_dst, in_rd,
        input  out_ready, flush, flags_save, flags_restore,
        input  alu_out, alu_c, alu_z, alu_n,
        output in_ready, alu_ctrl, alu_src, alu_dst,
        output out_valid, out_result, out_rd, out_wb,
        output ccr, illegal_op, retired
    );

    modport master (
        output in_valid, in_op, in_src, in_dst, in_rd,
        output out_ready, flush, flags_save, flags_restore,
        output alu_out, alu_c, alu_z, alu_n,
        input  in_ready, alu_ctrl, alu_src, alu_dst,
        input  out_valid, out_result, out_rd, out_wb,
        input  ccr, illegal_op, retired
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: sequences the shared ALU, buffers one
// result for MEM, owns the CCR with a shadow copy, counts retired ops.
module alu_exec_ctrl #(
    parameter int N    = 16,
    parameter int RA_W = 3
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_ctrl_if.slave bus
);
    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpNot  = 3'd1;
    localparam logic [2:0] OpMov  = 3'd2;
    localparam logic [2:0] OpSetc = 3'd4;
    localparam logic [2:0] OpClrc = 3'd5;

    logic            outValidQ;
    logic [N-1:0]    resultQ;
    logic [RA_W-1:0] rdQ;
    logic            wbQ;
    logic [2:0]      ccrQ;
    logic [2:0]      shadowQ;
    logic            illegalQ;
    logic [15:0]     retiredQ;

    logic       isAdd, isNot, isMov;
    logic       isSetc, isClrc, isIllegal;
    logic       doesWb;
    logic       accept, handoff, inReady;
    logic [2:0] ccrNext;

    assign isAdd     = bus.in_op == OpAdd;
    assign isNot     = bus.in_op == OpNot;
    assign isMov     = bus.in_op == OpMov;
    assign isSetc    = bus.in_op == OpSetc;
    assign isClrc    = bus.in_op == OpClrc;
    assign isIllegal = bus.in_op[2] & bus.in_op[1];
    assign doesWb    = isAdd | isNot | isMov;

    assign inReady = !outValidQ || bus.out_ready;
    assign accept  = bus.in_valid && inReady && !bus.flush;
    assign handoff = outValidQ && bus.out_ready;

    assign bus.alu_src = bus.in_src;
    assign bus.alu_dst = bus.in_dst;

    always_comb begin
        bus.alu_ctrl = 2'd3;
        unique case (1'b1)
            isAdd:   bus.alu_ctrl = 2'd0;
            isNot:   bus.alu_ctrl = 2'd1;
            isMov:   bus.alu_ctrl = 2'd2;
            default: bus.alu_ctrl = 2'd3;
        endcase
    end

    // ccr is {N, Z, C}; restore wins over any op-driven update
    always_comb begin
        ccrNext = ccrQ;
        if (accept) begin
            unique case (1'b1)
                isAdd:  ccrNext = {bus.alu_n, bus.alu_z, bus.alu_c};
                isNot:  ccrNext = {bus.alu_n, bus.alu_z, ccrQ[0]};
                isSetc: ccrNext[0] = 1'b1;
                isClrc: ccrNext[0] = 1'b0;
                default: ccrNext = ccrQ;
            endcase
        end
        if (bus.flags_restore) ccrNext = shadowQ;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValidQ <= 1'b0;
            resultQ   <= '0;
            rdQ       <= '0;
            wbQ       <= 1'b0;
            ccrQ      <= '0;
            shadowQ   <= '0;
            illegalQ  <= 1'b0;
            retiredQ  <= '0;
        end else begin
            ccrQ <= ccrNext;
            if (bus.flags_save) shadowQ <= ccrQ;
            if (accept && isIllegal) illegalQ <= 1'b1;
            if (handoff && retiredQ != 16'hFFFF)
                retiredQ <= retiredQ + 16'd1;
            if (bus.flush) begin
                outValidQ <= 1'b0;
            end else if (accept) begin
                outValidQ <= 1'b1;
                resultQ   <= doesWb ? bus.alu_out : '0;
                rdQ       <= bus.in_rd;
                wbQ       <= doesWb;
            end else if (handoff) begin
                outValidQ <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValidQ;
    assign bus.out_result = resultQ;
    assign bus.out_rd     = rdQ;
    assign bus.out_wb     = wbQ;
    assign bus.ccr        = ccrQ;
    assign bus.illegal_op = illegalQ;
    assign bus.retired    = retiredQ;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: vector table plus scoreboarded
// corner-case sequences against a behavioural model.
module tb_alu_exec_ctrl;
    logic clk;
    logic rst_n;

    alu_exec_ctrl_if #(.N(16), .RA_W(3)) bus();

    alu_exec_ctrl #(.N(16), .RA_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in for the shared ALU, driven by the controller's lines
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, bus.alu_src} + {1'b0, bus.alu_dst};
        bus.alu_out = bus.alu_dst;
        bus.alu_c   = 1'b0;
        case (bus.alu_ctrl)
            2'd0: begin
                bus.alu_out = sum[15:0];
                bus.alu_c   = sum[16];
            end
            2'd1: bus.alu_out = ~bus.alu_dst;
            2'd2: bus.alu_out = bus.alu_src;
            default: bus.alu_out = bus.alu_dst;
        endcase
        bus.alu_z = bus.alu_out == 16'h0000;
        bus.alu_n = bus.alu_out[15];
    end

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        wb;
    } sbT;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [2:0]  rd;
        logic [15:0] res;
        logic [2:0]  ccr;
    } vecT;

    sbT          sb[$];
    vecT         vecs[9];
    int          checks = 0;
    int          errors = 0;
    logic        mOutValid;
    logic [2:0]  mCcr;
    logic [2:0]  mShadow;
    logic        mIll;
    logic [15:0] mRetired;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expRes(input logic [2:0] op,
                                           input logic [15:0] s,
                                           input logic [15:0] d);
        case (op)
            3'd0: return s + d;
            3'd1: return ~d;
            3'd2: return s;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [1:0] expCtrl(input logic [2:0] op);
        case (op)
            3'd0: return 2'd0;
            3'd1: return 2'd1;
            3'd2: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [2:0] expCcr(input logic [2:0] c,
                                          input logic [2:0] op,
                                          input logic [15:0] s,
                                          input logic [15:0] d);
        logic [16:0] sum;
        logic [15:0] r;
        sum = {1'b0, s} + {1'b0, d};
        r   = expRes(op, s, d);
        case (op)
            3'd0: return {r[15], r == 16'h0, sum[16]};
            3'd1: return {r[15], r == 16'h0, c[0]};
            3'd4: return {c[2:1], 1'b1};
            3'd5: return {c[2:1], 1'b0};
            default: return c;
        endcase
    endfunction

    task automatic modelReset();
        mOutValid = 1'b0;
        mCcr      = '0;
        mShadow   = '0;
        mIll      = 1'b0;
        mRetired  = '0;
        sb.delete();
    endtask

    task automatic cyc(input logic v, input logic [2:0] op,
                       input logic [15:0] s, input logic [15:0] d,
                       input logic [2:0] rd, input logic ordy,
                       input logic fl, input logic sv,
                       input logic rs);
        logic acc, ho;
        logic [2:0] nc;
        sbT e;
        bus.in_valid      = v;
        bus.in_op         = op;
        bus.in_src        = s;
        bus.in_dst        = d;
        bus.in_rd         = rd;
        bus.out_ready     = ordy;
        bus.flush         = fl;
        bus.flags_save    = sv;
        bus.flags_restore = rs;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!mOutValid || ordy));
        chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(expCtrl(op)));
        acc = v && (!mOutValid || ordy) && !fl;
        ho  = mOutValid && ordy;
        if (ho || (fl && mOutValid)) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                if (ho) begin
                    chk("out_result", 32'(bus.out_result), 32'(e.res));
                    chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
                    chk("out_wb", 32'(bus.out_wb), 32'(e.wb));
                end
            end
        end
        if (ho && mRetired != 16'hFFFF) mRetired = mRetired + 16'd1;
        nc = acc ? expCcr(mCcr, op, s, d) : mCcr;
        if (rs) nc = mShadow;
        if (sv) mShadow = mCcr;
        mCcr = nc;
        if (acc && op[2] && op[1]) mIll = 1'b1;
        if (acc) sb.push_back('{expRes(op, s, d), rd, op <= 3'd2});
        if (fl) mOutValid = 1'b0;
        else if (acc) mOutValid = 1'b1;
        else if (ho) mOutValid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(mOutValid));
        chk("ccr", 32'(bus.ccr), 32'(mCcr));
        chk("illegal_op", 32'(bus.illegal_op), 32'(mIll));
        chk("retired", 32'(bus.retired), 32'(mRetired));
    endtask

    task automatic resetCheck();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_wb", 32'(bus.out_wb), 32'd0);
        chk("rst_ccr", 32'(bus.ccr), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [2:0] ccrKeep;
        vecs[0] = '{3'd0, 16'h8000, 16'h8000, 3'd1, 16'h0000, 3'b011};
        vecs[1] = '{3'd4, 16'h0000, 16'h0000, 3'd2, 16'h0000, 3'b011};
        vecs[2] = '{3'd1, 16'h0000, 16'h00FF, 3'd3, 16'hFF00, 3'b101};
        vecs[3] = '{3'd2, 16'h0000, 16'h1111, 3'd4, 16'h0000, 3'b101};
        vecs[4] = '{3'd5, 16'h0000, 16'h0000, 3'd5, 16'h0000, 3'b100};
        vecs[5] = '{3'd0, 16'h1234, 16'h0001, 3'd6, 16'h1235, 3'b000};
        vecs[6] = '{3'd1, 16'h0000, 16'hFFFF, 3'd7, 16'h0000, 3'b010};
        vecs[7] = '{3'd3, 16'hAAAA, 16'h5555, 3'd1, 16'h0000, 3'b010};
        vecs[8] = '{3'd0, 16'hFFFF, 16'h0001, 3'd2, 16'h0000, 3'b011};

        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_op         = 3'd3;
        bus.in_src        = '0;
        bus.in_dst        = '0;
        bus.in_rd         = '0;
        bus.out_ready     = 1'b0;
        bus.flush         = 1'b0;
        bus.flags_save    = 1'b0;
        bus.flags_restore = 1'b0;
        @(posedge clk);
        resetCheck();

        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, vecs[i].op, vecs[i].src, vecs[i].dst,
                vecs[i].rd, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_res", i),
                32'(bus.out_result), 32'(vecs[i].res));
            chk($sformatf("vec%0d_ccr", i),
                32'(bus.ccr), 32'(vecs[i].ccr));
        end

        // backpressure: result held, nothing accepted
        cyc(1, 3'd0, 16'd2, 16'd3, 3'd5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd0, 16'd7, 16'd7, 3'd6, 0, 0, 0, 0);
            chk("bp_hold", 32'(bus.out_result), 32'h5);
        end
        cyc(1, 3'd0, 16'd7, 16'd7, 3'd6, 1, 0, 0, 0);
        chk("bp_reload", 32'(bus.out_result), 32'hE);

        // flush kills the accepting op
        ccrKeep = mCcr;
        cyc(1, 3'd0, 16'hFFFF, 16'h0001, 3'd2, 1, 1, 0, 0);
        chk("flush_ccr", 32'(bus.ccr), 32'(ccrKeep));
        chk("flush_valid", 32'(bus.out_valid), 32'd0);

        // save / restore / swap
        cyc(1, 3'd4, 16'h0, 16'h0, 3'd0, 1, 0, 0, 0);
        cyc(1, 3'd1, 16'h0, 16'h00FF, 3'd1, 1, 0, 0, 0);
        cyc(0, 3'd3, 16'h0, 16'h0, 3'd0, 1, 0, 1, 0);
        cyc(1, 3'd5, 16'h0, 16'h0, 3'd0, 1, 0, 0, 0);
        chk("clrc_ccr", 32'(bus.ccr), 32'b100);
        cyc(1, 3'd0, 16'h0, 16'h0, 3'd3, 1, 0, 0, 1);
        chk("restore_ccr", 32'(bus.ccr), 32'b101);
        cyc(1, 3'd5, 16'h0, 16'h0, 3'd0, 1, 0, 0, 0);
        cyc(0, 3'd3, 16'h0, 16'h0, 3'd0, 1, 0, 1, 1);
        chk("swap_ccr", 32'(bus.ccr), 32'b101);
        cyc(0, 3'd3, 16'h0, 16'h0, 3'd0, 1, 0, 0, 1);
        chk("swap_shadow", 32'(bus.ccr), 32'b100);

        // illegal op, then reset in the middle of backpressure
        cyc(1, 3'd6, 16'h1, 16'h1, 3'd7, 1, 0, 0, 0);
        chk("ill_sticky", 32'(bus.illegal_op), 32'd1);
        chk("ill_wb", 32'(bus.out_wb), 32'd0);
        chk("ill_valid", 32'(bus.out_valid), 32'd1);
        cyc(1, 3'd0, 16'h1, 16'h1, 3'd1, 0, 0, 0, 0);
        cyc(1, 3'd0, 16'h1, 16'h1, 3'd1, 0, 0, 0, 0);
        resetCheck();
        cyc(0, 3'd3, 16'h0, 16'h0, 3'd0, 1, 0, 0, 1);
        chk("rst_shadow", 32'(bus.ccr), 32'd0);

        // retired saturation
        bus.in_valid      = 1'b1;
        bus.in_op         = 3'd3;
        bus.in_rd         = 3'd4;
        bus.out_ready     = 1'b1;
        bus.flags_restore = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_retired", 32'(bus.retired), 32'hFFFF);
        mOutValid = 1'b1;
        mRetired  = 16'hFFFF;
        sb.delete();
        sb.push_back('{16'h0, 3'd4, 1'b0});
        cyc(1, 3'd3, 16'h0, 16'h0, 3'd4, 1, 0, 0, 0);
        chk("sat_hold", 32'(bus.retired), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
